// File: rtl/gesture_event_buffer_pkg.sv
// Shared gesture definitions for the PAJ7620 gesture event path: code
// encoding, gesture byte bit positions and the decode / LED helpers.
package gesture_event_buffer_pkg;

  localparam int CODE_W = 4;

  typedef enum logic [CODE_W-1:0] {
    GEST_NONE = 4'd0,
    GEST_UP   = 4'd1,
    GEST_DOWN = 4'd2,
    GEST_LEFT = 4'd3,
    GEST_RGHT = 4'd4,
    GEST_FWD  = 4'd5,
    GEST_BACK = 4'd6,
    GEST_CW   = 4'd7,
    GEST_CCW  = 4'd8
  } gest_code_e;

  localparam int BIT_UP   = 0;
  localparam int BIT_DOWN = 1;
  localparam int BIT_LEFT = 2;
  localparam int BIT_RGHT = 3;
  localparam int BIT_FWD  = 4;
  localparam int BIT_BACK = 5;
  localparam int BIT_CW   = 6;
  localparam int BIT_CCW  = 7;

  // Lowest set bit wins; an all-zero byte decodes to GEST_NONE.
  function automatic logic [CODE_W-1:0] decode_gesture(input logic [7:0] gest);
    logic [CODE_W-1:0] code;
    code = GEST_NONE;
    for (int i = BIT_CCW; i >= BIT_UP; i--) begin
      if (gest[i]) code = CODE_W'(i + 1);
    end
    return code;
  endfunction

  // Code 1..8 to one-hot LED pattern; anything else gives no LED.
  function automatic logic [7:0] code_to_led(input logic [CODE_W-1:0] code);
    logic [7:0] led;
    led = '0;
    for (int i = 0; i < 8; i++) begin
      if (code == CODE_W'(i + 1)) led[i] = 1'b1;
    end
    return led;
  endfunction

endpackage

// File: rtl/gesture_event_buffer_fifo.sv
// gesture_fifo: DEPTH_P x 4-bit circular FIFO with push/pop/full/empty/count.
// A push while full is only taken when a pop frees a slot in the same cycle.
module gesture_fifo
  import gesture_event_buffer_pkg::*;
#(
  parameter int DEPTH_P = 4
) (
  input  logic              Clk_i,
  input  logic              Reset_i,
  input  logic              push,
  input  logic [CODE_W-1:0] push_code,
  input  logic              pop,
  output logic [CODE_W-1:0] head_code,
  output logic              full,
  output logic              empty,
  output logic [4:0]        count
);

  localparam int PTR_W = (DEPTH_P > 1) ? $clog2(DEPTH_P) : 1;
  localparam int CNT_W = $clog2(DEPTH_P + 1);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH_P);

  logic [CODE_W-1:0] mem [DEPTH_P];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic [CNT_W-1:0]  cnt_q;
  logic              do_push;
  logic              do_pop;

  assign empty     = (cnt_q == '0);
  assign full      = (cnt_q == FULL_CNT);
  assign do_pop    = pop & ~empty;
  assign do_push   = push & (~full | do_pop);
  assign head_code = empty ? '0 : mem[rd_ptr];
  assign count     = 5'(cnt_q);

  // Pointer and occupancy bookkeeping; power-of-two depth wraps naturally.
  always_ff @(posedge Clk_i or negedge Reset_i) begin
    if (!Reset_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt_q  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({do_push, do_pop})
        2'b10:   cnt_q <= cnt_q + CNT_W'(1);
        2'b01:   cnt_q <= cnt_q - CNT_W'(1);
        default: cnt_q <= cnt_q;
      endcase
    end
  end

  // Storage write; contents are masked by empty so they need no reset.
  always_ff @(posedge Clk_i) begin
    if (do_push) mem[wr_ptr] <= push_code;
  end

endmodule

// File: rtl/gesture_event_buffer.sv
// gesture_event_buffer: edge-detects the PAJ7620 data-available flag, decodes
// the gesture byte, queues codes in gesture_fifo and drives held gesture LEDs.
// Optional build macro GESTURE_REPEAT_FILTER_EN drops repeats of the last
// accepted code inside REPEAT_WINDOW_P cycles.
module gesture_event_buffer
  import gesture_event_buffer_pkg::*;
#(
  parameter int DEPTH_P         = 4,
  parameter int HOLD_CYCLES_P   = 25000000,
  parameter int REPEAT_WINDOW_P = 50000000
) (
  input  logic       Clk_i,
  input  logic       Reset_i,
  input  logic [7:0] Gesture_i,
  input  logic       Data_Available_i,
  output logic [3:0] Code_o,
  output logic       Valid_o,
  input  logic       Ready_i,
  output logic [4:0] Count_o,
  output logic [7:0] Led_o,
  output logic       Overflow_o
);

  localparam int HOLD_W = $clog2(HOLD_CYCLES_P + 1);
  localparam logic [HOLD_W-1:0] HOLD_LOAD = HOLD_W'(HOLD_CYCLES_P - 1);

  logic              da_p0;
  logic              sample_evt;
  logic [CODE_W-1:0] code_p0;
  logic              vld_p1;
  logic [CODE_W-1:0] code_p1;
  logic              accept;
  logic              fifo_full;
  logic              fifo_empty;
  logic [HOLD_W-1:0] hold_q;

  assign sample_evt = Data_Available_i & ~da_p0;
  assign code_p0    = decode_gesture(Gesture_i);

  // Delay flop for rising-edge detection of the data-available flag.
  always_ff @(posedge Clk_i or negedge Reset_i) begin
    if (!Reset_i) da_p0 <= 1'b0;
    else          da_p0 <= Data_Available_i;
  end

  // ---- stage p0 -> p1: register decoded code and push request ----
  always_ff @(posedge Clk_i or negedge Reset_i) begin
    if (!Reset_i) vld_p1 <= 1'b0;
    else          vld_p1 <= sample_evt && (code_p0 != GEST_NONE);
  end

  // Code data register, captured only on a sample event.
  always_ff @(posedge Clk_i) begin
    if (sample_evt) code_p1 <= code_p0;
  end

`ifdef GESTURE_REPEAT_FILTER_EN
  localparam int WIN_W = $clog2(REPEAT_WINDOW_P + 1);
  localparam logic [WIN_W-1:0] WIN_LOAD = WIN_W'(REPEAT_WINDOW_P - 1);

  logic [WIN_W-1:0]  win_q;
  logic [CODE_W-1:0] last_code_q;

  assign accept = vld_p1 & ~((code_p1 == last_code_q) && (win_q != '0));

  // Repeat window: restarted only by an accepted gesture, saturates at 0.
  always_ff @(posedge Clk_i or negedge Reset_i) begin
    if (!Reset_i) begin
      win_q       <= '0;
      last_code_q <= '0;
    end else if (accept) begin
      win_q       <= WIN_LOAD;
      last_code_q <= code_p1;
    end else if (win_q != '0) begin
      win_q <= win_q - WIN_W'(1);
    end
  end
`else
  logic unused_repeat_window;

  assign accept = vld_p1;
  assign unused_repeat_window = ^REPEAT_WINDOW_P;
`endif

  // ---- stage p1 -> FIFO / LEDs ----
  gesture_fifo #(
    .DEPTH_P (DEPTH_P)
  ) u_fifo (
    .Clk_i     (Clk_i),
    .Reset_i   (Reset_i),
    .push      (accept),
    .push_code (code_p1),
    .pop       (Ready_i),
    .head_code (Code_o),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (Count_o)
  );

  assign Valid_o = ~fifo_empty;

  // Sticky overflow: an accepted gesture met a full FIFO with no pop.
  always_ff @(posedge Clk_i or negedge Reset_i) begin
    if (!Reset_i)                              Overflow_o <= 1'b0;
    else if (accept && fifo_full && !Ready_i)  Overflow_o <= 1'b1;
  end

  // LED hold timer: each accepted gesture replaces the LED and restarts it.
  always_ff @(posedge Clk_i or negedge Reset_i) begin
    if (!Reset_i) begin
      Led_o  <= '0;
      hold_q <= '0;
    end else if (accept) begin
      Led_o  <= code_to_led(code_p1);
      hold_q <= HOLD_LOAD;
    end else if (hold_q != '0) begin
      hold_q <= hold_q - HOLD_W'(1);
    end else begin
      Led_o <= '0;
    end
  end

endmodule

// File: tb/tb_gesture_event_buffer.sv
// Directed self-checking bench for gesture_event_buffer (DEPTH_P=4,
// HOLD_CYCLES_P=10, REPEAT_WINDOW_P=20). Inputs change on the falling edge,
// outputs are checked on the falling edge.
module tb_gesture_event_buffer;

  logic       Clk_i;
  logic       Reset_i;
  logic [7:0] Gesture_i;
  logic       Data_Available_i;
  logic [3:0] Code_o;
  logic       Valid_o;
  logic       Ready_i;
  logic [4:0] Count_o;
  logic [7:0] Led_o;
  logic       Overflow_o;

  int checks;
  int failures;

  gesture_event_buffer #(
    .DEPTH_P         (4),
    .HOLD_CYCLES_P   (10),
    .REPEAT_WINDOW_P (20)
  ) dut (
    .Clk_i            (Clk_i),
    .Reset_i          (Reset_i),
    .Gesture_i        (Gesture_i),
    .Data_Available_i (Data_Available_i),
    .Code_o           (Code_o),
    .Valid_o          (Valid_o),
    .Ready_i          (Ready_i),
    .Count_o          (Count_o),
    .Led_o            (Led_o),
    .Overflow_o       (Overflow_o)
  );

  initial Clk_i = 1'b0;
  always #5 Clk_i = ~Clk_i;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge Clk_i);
    @(negedge Clk_i);
  endtask

  // One-cycle data-available pulse; the push lands on the second edge.
  task automatic pulse(input logic [7:0] g);
    Gesture_i        = g;
    Data_Available_i = 1'b1;
    step();
    Data_Available_i = 1'b0;
    step();
  endtask

  initial begin
    checks           = 0;
    failures         = 0;
    Reset_i          = 1'b0;
    Gesture_i        = 8'h00;
    Data_Available_i = 1'b0;
    Ready_i          = 1'b0;
    @(negedge Clk_i);
    @(negedge Clk_i);
    check("rst_count", Count_o, 0);
    check("rst_valid", Valid_o, 0);
    check("rst_code", Code_o, 0);
    check("rst_led", Led_o, 0);
    check("rst_ovf", Overflow_o, 0);
    Reset_i = 1'b1;
    step();

    // Held level counts once; valid two edges after the rise.
    Gesture_i        = 8'h04;
    Data_Available_i = 1'b1;
    step();
    check("t2_valid_e1", Valid_o, 0);
    step();
    check("t2_valid_e2", Valid_o, 1);
    check("t2_code", Code_o, 3);
    check("t2_led", Led_o, 8'h04);
    step();
    step();
    step();
    Data_Available_i = 1'b0;
    check("t2_count_once", Count_o, 1);
    // LED set after edge 2 must still be on after edge 11, off after edge 12.
    repeat (6) step();
    check("t6_led_held", Led_o, 8'h04);
    step();
    check("t6_led_clear", Led_o, 8'h00);

    // Zero byte discarded, 0x30 decodes to code 5.
    pulse(8'h00);
    step();
    check("t3_zero_count", Count_o, 1);
    check("t3_zero_led", Led_o, 8'h00);
    pulse(8'h30);
    check("t3_count", Count_o, 2);
    check("t3_head", Code_o, 3);
    check("t3_led", Led_o, 8'h10);
    Ready_i = 1'b1;
    step();
    Ready_i = 1'b0;
    check("t3_pop_count", Count_o, 1);
    check("t3_code5", Code_o, 5);
    // Push and pop together at count 1.
    Gesture_i        = 8'h40;
    Data_Available_i = 1'b1;
    step();
    Data_Available_i = 1'b0;
    Ready_i          = 1'b1;
    step();
    Ready_i = 1'b0;
    check("c1_pushpop_count", Count_o, 1);
    check("c1_pushpop_code", Code_o, 7);
    Ready_i = 1'b1;
    step();
    Ready_i = 1'b0;
    check("c1_empty_count", Count_o, 0);
    check("c1_empty_valid", Valid_o, 0);
    check("c1_empty_code", Code_o, 0);

    // Full FIFO with simultaneous pop and push.
    pulse(8'h01);
    pulse(8'h02);
    pulse(8'h04);
    pulse(8'h08);
    check("t5_full_count", Count_o, 4);
    check("t5_led", Led_o, 8'h08);
    Gesture_i        = 8'h40;
    Data_Available_i = 1'b1;
    step();
    Data_Available_i = 1'b0;
    Ready_i          = 1'b1;
    step();
    Ready_i = 1'b0;
    check("t5_count_kept", Count_o, 4);
    check("t5_no_ovf", Overflow_o, 0);
    Ready_i = 1'b1;
    check("t5_drain0", Code_o, 2);
    step();
    check("t5_drain1", Code_o, 3);
    step();
    check("t5_drain2", Code_o, 4);
    step();
    check("t5_drain3_tail", Code_o, 7);
    step();
    Ready_i = 1'b0;
    check("t5_drained", Count_o, 0);

    // Overflow: five events into a four-deep FIFO.
    pulse(8'h01);
    pulse(8'h02);
    pulse(8'h0C);
    pulse(8'h08);
    pulse(8'h10);
    check("t4_count", Count_o, 4);
    check("t4_ovf", Overflow_o, 1);
    check("t4_led", Led_o, 8'h10);
    Ready_i = 1'b1;
    check("t4_drain0", Code_o, 1);
    step();
    check("t4_drain1", Code_o, 2);
    step();
    check("t4_drain2", Code_o, 3);
    step();
    check("t4_drain3", Code_o, 4);
    step();
    Ready_i = 1'b0;
    check("t4_drained", Count_o, 0);
    check("t4_ovf_sticky", Overflow_o, 1);

    // Asynchronous reset mid-run with three entries queued.
    pulse(8'h01);
    pulse(8'h02);
    pulse(8'h04);
    check("t1_pre_count", Count_o, 3);
    #2 Reset_i = 1'b0;
    #1;
    check("t1_async_count", Count_o, 0);
    check("t1_async_valid", Valid_o, 0);
    check("t1_async_code", Code_o, 0);
    check("t1_async_led", Led_o, 0);
    check("t1_async_ovf", Overflow_o, 0);
    @(negedge Clk_i);
    Reset_i = 1'b1;
    step();
    check("t1_post_count", Count_o, 0);
    check("t1_post_led", Led_o, 0);

    // Repeat of code 1: rises 5 cycles apart, then 25 cycles after the first.
    pulse(8'h01);
    step();
    step();
    step();
    pulse(8'h01);
`ifdef GESTURE_REPEAT_FILTER_EN
    check("rf_near_dropped", Count_o, 1);
`else
    check("rf_near_kept", Count_o, 2);
`endif
    repeat (18) step();
    pulse(8'h01);
`ifdef GESTURE_REPEAT_FILTER_EN
    check("rf_far_kept", Count_o, 2);
`else
    check("rf_far_kept", Count_o, 3);
`endif
    check("rf_led", Led_o, 8'h01);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
